inst_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the single-cycle datapath and its instruction memory. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instructions, and writes them to consecutive word addresses of instruction memory. Holds the datapath in reset (`core_rst`) until the image is fully written, then releases it to execute from PC 0.

---
 rtl/inst_loader.sv | 154 +++++++++++++++
 tb/tb_inst_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
`default_nettype none
// ============================================================================
// Module   : inst_loader
// Brief    : Boot-time loader; assembles a little-endian byte stream into
//            32-bit words, writes instruction memory and releases core_rst.
//            Optional trailing checksum byte: define LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module inst_loader #(
   parameter int DEPTH = 64,
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             reload,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic             core_rst,
   output logic             done,
   output logic             err,
   output logic [LEN_W-1:0] words_loaded
);

   typedef enum logic [2:0] {
      S_LEN0 = 3'd0,
      S_LEN1 = 3'd1,
      S_DATA = 3'd2,
`ifdef LOADER_CHECKSUM_EN
      S_CSUM = 3'd3,
`endif
      S_WAIT = 3'd4,
      S_RUN  = 3'd5,
      S_ERR  = 3'd6
   } state_t;

`ifdef LOADER_CHECKSUM_EN
   localparam state_t c_END = S_CSUM;
`else
   localparam state_t c_END = S_WAIT;
`endif
   localparam logic [LEN_W-1:0] c_DEPTH = LEN_W'(DEPTH);

   state_t           r_state;
   logic [7:0]       r_len_lo;
   logic [LEN_W-1:0] r_len;
   logic [1:0]       r_lane;

   logic             w_xfer;
   logic [LEN_W-1:0] w_len_n;
   logic [LEN_W-1:0] w_wl_next;
   logic [31:0]      w_addr;

   assign in_ready  = (r_state == S_LEN0) || (r_state == S_LEN1) ||
`ifdef LOADER_CHECKSUM_EN
                      (r_state == S_CSUM) ||
`endif
                      (r_state == S_DATA);
   assign w_xfer    = in_valid && in_ready;
   assign w_len_n   = LEN_W'({in_data, r_len_lo});
   assign w_wl_next = words_loaded + LEN_W'(1);
   assign w_addr    = 32'(words_loaded) << 2;

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] r_sum;
   logic [7:0] w_sum_next;
   assign w_sum_next = r_sum + in_data;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_LEN0;
         r_len_lo     <= 8'd0;
         r_len        <= '0;
         r_lane       <= 2'd0;
         mem_we       <= 1'b0;
         mem_addr     <= 32'd0;
         mem_wdata    <= 32'd0;
         core_rst     <= 1'b1;
         done         <= 1'b0;
         err          <= 1'b0;
         words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
         r_sum        <= 8'd0;
`endif
      end else begin
         // Status outputs follow the state one cycle later, so core_rst
         // drops one edge after entering RUN and never glitches.
         mem_we   <= 1'b0;
         core_rst <= (r_state != S_RUN);
         done     <= (r_state == S_RUN);
         err      <= (r_state == S_ERR);
`ifdef LOADER_CHECKSUM_EN
         if (w_xfer)
            r_sum <= w_sum_next;
`endif
         case (r_state)
            S_LEN0: begin
               if (w_xfer) begin
                  r_len_lo <= in_data;
                  r_state  <= S_LEN1;
               end
            end
            S_LEN1: begin
               if (w_xfer) begin
                  r_len <= w_len_n;
                  if (w_len_n > c_DEPTH)
                     r_state <= S_ERR;
                  else if (w_len_n == '0)
                     r_state <= c_END;
                  else
                     r_state <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_xfer) begin
                  mem_wdata[{r_lane, 3'b000} +: 8] <= in_data;
                  r_lane <= r_lane + 2'd1;
                  if (r_lane == 2'd3) begin
                     mem_we       <= 1'b1;
                     mem_addr     <= w_addr;
                     words_loaded <= w_wl_next;
                     if (w_wl_next == r_len)
                        r_state <= c_END;
                  end
               end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
               if (w_xfer)
                  r_state <= (w_sum_next == 8'd0) ? S_WAIT : S_ERR;
            end
`endif
            S_WAIT: r_state <= S_RUN;
            S_RUN, S_ERR: begin
               if (reload) begin
                  r_state      <= S_LEN0;
                  r_lane       <= 2'd0;
                  words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
                  r_sum        <= 8'd0;
`endif
               end
            end
            default: r_state <= S_LEN0;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_inst_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_loader
// Brief    : Directed self-checking bench for inst_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        reload;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        core_rst;
   logic        done;
   logic        err;
   logic [15:0] words_loaded;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic [31:0] wa[$];
   logic [31:0] wd[$];
   int          wc[$];

   logic [7:0] img [10] = '{8'h02, 8'h00, 8'h13, 8'h03, 8'h50,
                            8'h00, 8'h93, 8'h03, 8'hA0, 8'h00};
`ifdef LOADER_CHECKSUM_EN
   logic [7:0] img1 [6] = '{8'h01, 8'h00, 8'h13, 8'h03, 8'h50, 8'h00};
`endif

   inst_loader #(.DEPTH(64), .LEN_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .reload       (reload),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .core_rst     (core_rst),
      .done         (done),
      .err          (err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   // Instruction-memory model: captures each write at the edge ending the strobe
   always @(posedge clk) begin
      cyc++;
      if (mem_we) begin
         wa.push_back(mem_addr);
         wd.push_back(mem_wdata);
         wc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      repeat (gap) tick();
      in_data  = b;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      if (!in_ready)
         check("ready_timeout", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   // Sends img[first..9]; the running sum is seeded with any bytes already sent
   task automatic send_stream(input int first, input int gap);
      logic [7:0] sum;
      sum = 8'h00;
      for (int i = 0; i < 10; i++) begin
         sum = sum + img[i];
         if (i >= first)
            send_byte(img[i], (i == first) ? 0 : gap);
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(8'h00 - sum, gap);
`endif
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      tick();
      reload = 1'b0;
   endtask

   task automatic check_run();
      check("wait_ready", 32'(in_ready), 32'd0);
      check("wait_core_rst0", 32'(core_rst), 32'd1);
      tick();
      check("wait_core_rst1", 32'(core_rst), 32'd1);
      tick();
      check("run_core_rst", 32'(core_rst), 32'd0);
      check("run_done", 32'(done), 32'd1);
      check("run_ready", 32'(in_ready), 32'd0);
      check("run_words", 32'(words_loaded), 32'd2);
   endtask

   task automatic check_writes(input int base, input int spacing);
      check("wr_count", wa.size(), base + 2);
      if (wa.size() >= base + 2) begin
         check("wr0_addr", wa[base], 32'h0000_0000);
         check("wr0_data", wd[base], 32'h0050_0313);
         check("wr1_addr", wa[base+1], 32'h0000_0004);
         check("wr1_data", wd[base+1], 32'h00A0_0393);
         check("wr_spacing", wc[base+1] - wc[base], spacing);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h02;
      reload   = 1'b0;
      repeat (3) tick();
      check("rst_core_rst", 32'(core_rst), 32'd1);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_words", 32'(words_loaded), 32'd0);
      check("rst_addr", mem_addr, 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      check("rst_no_write", wa.size(), 32'd0);

      // First byte is taken on the first edge after reset release
      rst = 1'b0;
      tick();
      in_valid = 1'b0;
      send_stream(1, 0);
      check_run();
      check_writes(0, 4);

      pulse_reload();
      check("reload_ready", 32'(in_ready), 32'd1);
      check("reload_words", 32'(words_loaded), 32'd0);
      tick();
      check("reload_core_rst", 32'(core_rst), 32'd1);
      check("reload_done", 32'(done), 32'd0);

      // Overflow; the reload pulse in LEN1 must be ignored
      send_byte(8'h41, 0);
      pulse_reload();
      send_byte(8'h00, 0);
      check("ovf_ready", 32'(in_ready), 32'd0);
      tick();
      check("ovf_err", 32'(err), 32'd1);
      check("ovf_core_rst", 32'(core_rst), 32'd1);
      check("ovf_no_write", wa.size(), 32'd2);
      pulse_reload();
      check("ovf_reload_ready", 32'(in_ready), 32'd1);
      tick();
      check("ovf_err_clear", 32'(err), 32'd0);

      // Stalled stream: two idle cycles between bytes
      send_stream(0, 2);
      check_run();
      check_writes(2, 12);

      // Mid-load reset discards the partial word
      pulse_reload();
      for (int i = 0; i < 5; i++)
         send_byte(img[i], 0);
      rst = 1'b1;
      tick();
      check("midrst_we", 32'(mem_we), 32'd0);
      check("midrst_words", 32'(words_loaded), 32'd0);
      check("midrst_core_rst", 32'(core_rst), 32'd1);
      check("midrst_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;
      tick();
      tick();
      check("midrst_no_write", wa.size(), 32'd4);
      send_stream(0, 0);
      check_run();
      check_writes(4, 4);

`ifdef LOADER_CHECKSUM_EN
      pulse_reload();
      for (int i = 0; i < 6; i++)
         send_byte(img1[i], 0);
      send_byte(8'h99, 0);
      tick();
      tick();
      check("csum_ok_done", 32'(done), 32'd1);
      check("csum_ok_core_rst", 32'(core_rst), 32'd0);
      check("csum_ok_err", 32'(err), 32'd0);

      pulse_reload();
      for (int i = 0; i < 6; i++)
         send_byte(img1[i], 0);
      send_byte(8'h9A, 0);
      check("csum_bad_ready", 32'(in_ready), 32'd0);
      tick();
      check("csum_bad_err", 32'(err), 32'd1);
      tick();
      check("csum_bad_core_rst", 32'(core_rst), 32'd1);
      check("csum_bad_done", 32'(done), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
